// File: rtl/operand_selector_param_if.sv
// Operand selector bundle: control/request signals from the UI FSM, slot metadata from the store, selection results out.
// Latency: none (wires only).
// Backpressure: none; start is level-sampled by the selector, done is a one-cycle pulse.
interface operand_selector_param_if #(
  parameter int SLOTS = 10,
  parameter int IDW   = 4,
  parameter int DIMW  = 3
);
  // request side
  logic                  start;
  logic                  abort;
  logic                  manual_mode;
  logic [2:0]            op_type;
  logic [IDW-1:0]        user_id_a;
  logic [IDW-1:0]        user_id_b;
  logic                  user_valid;
  // matrix store metadata, slot i at [i*DIMW +: DIMW]
  logic [SLOTS*DIMW-1:0] meta_m_flat;
  logic [SLOTS*DIMW-1:0] meta_n_flat;
  logic [SLOTS-1:0]      meta_valid_flat;
  // selection result
  logic [IDW-1:0]        sel_a;
  logic [IDW-1:0]        sel_b;
  logic [DIMW-1:0]       res_m;
  logic [DIMW-1:0]       res_n;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [2:0]            err_code;

  // Controller side: issues requests and store metadata, consumes results.
  modport master (
    output start, abort, manual_mode, op_type, user_id_a, user_id_b, user_valid,
    output meta_m_flat, meta_n_flat, meta_valid_flat,
    input  sel_a, sel_b, res_m, res_n, busy, done, error, err_code
  );

  // Selector side.
  modport slave (
    input  start, abort, manual_mode, op_type, user_id_a, user_id_b, user_valid,
    input  meta_m_flat, meta_n_flat, meta_valid_flat,
    output sel_a, sel_b, res_m, res_n, busy, done, error, err_code
  );
endinterface

// File: rtl/operand_selector_param.sv
// Operand selector: picks matrix slots A/B from user IDs or an LFSR, validates them for the op, reports result dims.
// Latency: user_valid sampled at edge t -> CHECK cycle -> done pulse visible after edge t+1; random mode is draw-dependent.
// Backpressure: none; start ignored while busy, abort always wins and returns to IDLE without done.
module operand_selector_param #(
  parameter int          SLOTS     = 10,
  parameter int          IDW       = 4,
  parameter int          DIMW      = 3,
  parameter int          MAX_TRIES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                     clk,
  input logic                     rst_n,
  operand_selector_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_RAND_A  = 3'd2,
    S_RAND_B  = 3'd3,
    S_CHECK   = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [2:0] OP_TRANS  = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SCALAR = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_CONV   = 3'd4;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_A_RANGE = 3'd1;
  localparam logic [2:0] E_A_EMPTY = 3'd2;
  localparam logic [2:0] E_B_BAD   = 3'd3;
  localparam logic [2:0] E_DIM     = 3'd4;
  localparam logic [2:0] E_TRIES   = 3'd5;
  localparam logic [2:0] E_OP      = 3'd6;

  localparam logic [IDW:0] SLOTS_W = (IDW+1)'(SLOTS);
  localparam logic [7:0]   MAX_T   = 8'(MAX_TRIES);

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      try_q, try_d;
  logic [2:0]      op_q, op_d;
  logic            manual_q, manual_d;
  logic [IDW-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [DIMW-1:0] m_a_q, m_a_d, n_a_q, n_a_d, m_b_q, m_b_d, n_b_q, n_b_d;
  logic            a_rng_q, a_rng_d, a_vld_q, a_vld_d;
  logic            b_rng_q, b_rng_d, b_vld_q, b_vld_d;
  logic [DIMW-1:0] res_m_q, res_m_d, res_n_q, res_n_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [2:0]      code_q, code_d;

  logic            lfsr_fb;
  logic [IDW-1:0]  draw;
  logic [IDW-1:0]  look_id;
  logic            look_rng, look_vld;
  logic [DIMW-1:0] look_m, look_n;
  logic            ub_rng, ub_vld;
  logic [DIMW-1:0] ub_m, ub_n;
  logic            two_op;
  logic [2:0]      chk_code;
  logic [DIMW-1:0] chk_m, chk_n;

  // x^16+x^14+x^13+x^11+1, shifting left every cycle regardless of state.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign draw    = lfsr_q[IDW-1:0];

  // Port A of the lookup serves the manual A id in WAIT_IN and the LFSR draw otherwise.
  assign look_id  = (state_q == S_WAIT_IN) ? bus.user_id_a : draw;
  assign look_rng = ({1'b0, look_id} < SLOTS_W);
  assign ub_rng   = ({1'b0, bus.user_id_b} < SLOTS_W);

  // Slot metadata lookup; an id past the last slot matches nothing and reads as empty 0x0.
  always_comb begin
    look_m   = '0;
    look_n   = '0;
    look_vld = 1'b0;
    ub_m     = '0;
    ub_n     = '0;
    ub_vld   = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (look_id == IDW'(i)) begin
        look_m   = bus.meta_m_flat[i*DIMW +: DIMW];
        look_n   = bus.meta_n_flat[i*DIMW +: DIMW];
        look_vld = bus.meta_valid_flat[i];
      end
      if (bus.user_id_b == IDW'(i)) begin
        ub_m   = bus.meta_m_flat[i*DIMW +: DIMW];
        ub_n   = bus.meta_n_flat[i*DIMW +: DIMW];
        ub_vld = bus.meta_valid_flat[i];
      end
    end
  end

  assign two_op = (op_q == OP_ADD) || (op_q == OP_MUL) || (op_q == OP_CONV);

  // Operand check in priority order plus result dimensions for a passing pair.
  always_comb begin
    chk_code = E_NONE;
    chk_m    = m_a_q;
    chk_n    = n_a_q;
    if (!a_rng_q) begin
      chk_code = E_A_RANGE;
    end else if (!a_vld_q) begin
      chk_code = E_A_EMPTY;
    end else if (two_op && !(b_rng_q && b_vld_q)) begin
      chk_code = E_B_BAD;
    end else begin
      case (op_q)
        OP_TRANS: begin
          chk_m = n_a_q;
          chk_n = m_a_q;
        end
        OP_ADD: begin
          if ((m_a_q != m_b_q) || (n_a_q != n_b_q)) chk_code = E_DIM;
        end
        OP_MUL: begin
          chk_n = n_b_q;
          if (n_a_q != m_b_q) chk_code = E_DIM;
        end
        OP_CONV: begin
          // valid-window size, wraps at DIMW bits
          chk_m = m_a_q - m_b_q + DIMW'(1);
          chk_n = n_a_q - n_b_q + DIMW'(1);
          if ((m_b_q > m_a_q) || (n_b_q > n_a_q)) chk_code = E_DIM;
        end
        default: ; // scalar keeps A's dimensions
      endcase
    end
  end

  // Next-state and datapath updates; abort is tested first in every state.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_fb};
    try_d    = try_q;
    op_d     = op_q;
    manual_d = manual_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    m_a_d    = m_a_q;
    n_a_d    = n_a_q;
    m_b_d    = m_b_q;
    n_b_d    = n_b_q;
    a_rng_d  = a_rng_q;
    a_vld_d  = a_vld_q;
    b_rng_d  = b_rng_q;
    b_vld_d  = b_vld_q;
    res_m_d  = res_m_q;
    res_n_d  = res_n_q;
    done_d   = 1'b0;
    error_d  = error_q;
    code_d   = code_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          error_d = 1'b0;
          code_d  = E_NONE;
        end else if (bus.start) begin
          error_d  = 1'b0;
          code_d   = E_NONE;
          try_d    = '0;
          op_d     = bus.op_type;
          manual_d = bus.manual_mode;
          if (bus.op_type > OP_CONV) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = E_OP;
          end else if (bus.manual_mode) begin
            state_d = S_WAIT_IN;
          end else begin
            state_d = S_RAND_A;
          end
        end
      end

      S_WAIT_IN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.user_valid) begin
          sel_a_d = bus.user_id_a;
          sel_b_d = bus.user_id_b;
          m_a_d   = look_m;
          n_a_d   = look_n;
          a_rng_d = look_rng;
          a_vld_d = look_vld;
          m_b_d   = ub_m;
          n_b_d   = ub_n;
          b_rng_d = ub_rng;
          b_vld_d = ub_vld;
          state_d = S_CHECK;
        end
      end

      S_RAND_A, S_RAND_B: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (try_q == MAX_T) begin
          state_d = S_ERR;
          error_d = 1'b1;
          code_d  = E_TRIES;
        end else begin
          try_d = try_q + 8'd1;
          if (look_rng && look_vld) begin
            if (state_q == S_RAND_A) begin
              sel_a_d = draw;
              m_a_d   = look_m;
              n_a_d   = look_n;
              a_rng_d = 1'b1;
              a_vld_d = 1'b1;
              if (two_op) begin
                state_d = S_RAND_B;
              end else begin
                sel_b_d = '0;
                state_d = S_CHECK;
              end
            end else begin
              sel_b_d = draw;
              m_b_d   = look_m;
              n_b_d   = look_n;
              b_rng_d = 1'b1;
              b_vld_d = 1'b1;
              state_d = S_CHECK;
            end
          end
        end
      end

      S_CHECK: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (chk_code == E_NONE) begin
          done_d  = 1'b1;
          res_m_d = chk_m;
          res_n_d = chk_n;
          state_d = S_IDLE;
        end else if (!manual_q && (chk_code == E_DIM)) begin
          // incompatible random pair: draw a fresh pair, try budget carries over
          state_d = S_RAND_A;
        end else begin
          state_d = S_ERR;
          error_d = 1'b1;
          code_d  = chk_code;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      try_q    <= '0;
      op_q     <= '0;
      manual_q <= 1'b0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      m_a_q    <= '0;
      n_a_q    <= '0;
      m_b_q    <= '0;
      n_b_q    <= '0;
      a_rng_q  <= 1'b0;
      a_vld_q  <= 1'b0;
      b_rng_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      res_m_q  <= '0;
      res_n_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      try_q    <= try_d;
      op_q     <= op_d;
      manual_q <= manual_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      m_a_q    <= m_a_d;
      n_a_q    <= n_a_d;
      m_b_q    <= m_b_d;
      n_b_q    <= n_b_d;
      a_rng_q  <= a_rng_d;
      a_vld_q  <= a_vld_d;
      b_rng_q  <= b_rng_d;
      b_vld_q  <= b_vld_d;
      res_m_q  <= res_m_d;
      res_n_q  <= res_n_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.res_m    = res_m_q;
  assign bus.res_n    = res_n_q;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_operand_selector_param.sv
// Bench for operand_selector_param: directed manual/random selections checked through an expected-event queue.
// Latency: checks done arrives two edges after user_valid is driven.
// Backpressure: n/a; every wait on the design is cycle-bounded.
module tb_operand_selector_param;
  localparam int SLOTS = 10;
  localparam int IDW   = 4;
  localparam int DIMW  = 3;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_RAND = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_selector_param_if #(.SLOTS(SLOTS), .IDW(IDW), .DIMW(DIMW)) bus ();

  operand_selector_param #(
    .SLOTS(SLOTS), .IDW(IDW), .DIMW(DIMW), .MAX_TRIES(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int    kind;
    string name;
    int    op;
    int    sa;
    int    sb;
    int    rm;
    int    rn;
    int    code;
    int    cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tm[SLOTS];
  int   tn[SLOTS];
  bit   tv[SLOTS];
  int   rand_outcome = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  function automatic void exp_res(input int op, input int ma, input int na, input int mb, input int nb,
                                  output int rm, output int rn);
    case (op)
      0:       begin rm = na; rn = ma; end
      3:       begin rm = ma; rn = nb; end
      4:       begin rm = (ma - mb + 1) & 7; rn = (na - nb + 1) & 7; end
      default: begin rm = ma; rn = na; end
    endcase
  endfunction

  // Monitor: every done pulse or rising error is matched against the oldest expectation.
  exp_t e;
  logic err_prev = 1'b0;
  int   sa, sb, rm, rn;
  bit   two, a_ok, b_ok;
  always @(negedge clk) begin
    if (bus.done || (bus.error && !err_prev)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event_done", int'(bus.done), 0);
        chk("unexpected_event_error", int'(bus.error), 0);
      end else begin
        e = sbq.pop_front();
        if (e.kind == K_DONE) begin
          chk({e.name, "_done"}, int'(bus.done), 1);
          chk({e.name, "_error"}, int'(bus.error), 0);
          chk({e.name, "_sel_a"}, int'(bus.sel_a), e.sa);
          chk({e.name, "_sel_b"}, int'(bus.sel_b), e.sb);
          chk({e.name, "_res_m"}, int'(bus.res_m), e.rm);
          chk({e.name, "_res_n"}, int'(bus.res_n), e.rn);
          if (e.cyc > 0) chk({e.name, "_latency_cycle"}, cyc, e.cyc);
        end else if (e.kind == K_ERR) begin
          chk({e.name, "_no_done"}, int'(bus.done), 0);
          chk({e.name, "_error"}, int'(bus.error), 1);
          chk({e.name, "_err_code"}, int'(bus.err_code), e.code);
        end else if (bus.done) begin
          rand_outcome = 1;
          sa   = int'(bus.sel_a);
          sb   = int'(bus.sel_b);
          two  = (e.op == 1) || (e.op == 3) || (e.op == 4);
          a_ok = (sa < SLOTS) && tv[(sa < SLOTS) ? sa : 0];
          b_ok = (sb < SLOTS) && tv[(sb < SLOTS) ? sb : 0];
          chk({e.name, "_a_is_occupied_slot"}, int'(a_ok), 1);
          if (two) chk({e.name, "_b_is_occupied_slot"}, int'(b_ok), 1);
          else     chk({e.name, "_sel_b_zero"}, sb, 0);
          if (a_ok && (!two || b_ok)) begin
            exp_res(e.op, tm[sa], tn[sa], tm[two ? sb : sa], tn[two ? sb : sa], rm, rn);
            chk({e.name, "_res_m"}, int'(bus.res_m), rm);
            chk({e.name, "_res_n"}, int'(bus.res_n), rn);
          end
        end else begin
          rand_outcome = 2;
          chk({e.name, "_exhausted_code"}, int'(bus.err_code), 5);
        end
      end
    end
    err_prev = bus.error;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_meta();
    for (int i = 0; i < SLOTS; i++) begin
      bus.meta_m_flat[i*DIMW +: DIMW] = DIMW'(tm[i]);
      bus.meta_n_flat[i*DIMW +: DIMW] = DIMW'(tn[i]);
      bus.meta_valid_flat[i]          = tv[i];
    end
  endtask

  task automatic set_slot(int i, int m, int n, bit v);
    tm[i] = m;
    tn[i] = n;
    tv[i] = v;
  endtask

  task automatic push(int kind, string name, int op, int sa_, int sb_, int rm_, int rn_, int code, int c);
    exp_t x;
    x.kind = kind; x.name = name; x.op = op; x.sa = sa_; x.sb = sb_;
    x.rm = rm_; x.rn = rn_; x.code = code; x.cyc = c;
    sbq.push_back(x);
  endtask

  task automatic wait_sb(string name, int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) tick();
    chk({name, "_pending_after_timeout"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic start_sel(int op, bit manual);
    bus.op_type     = 3'(op);
    bus.manual_mode = manual;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic issue_ids(string name, int op, int ida, int idb, int kind, int rm_, int rn_, int code);
    bus.user_id_a  = IDW'(ida);
    bus.user_id_b  = IDW'(idb);
    bus.user_valid = 1'b1;
    push(kind, name, op, ida, idb, rm_, rn_, code, (kind == K_DONE) ? cyc + 2 : 0);
    tick();
    bus.user_valid = 1'b0;
    wait_sb(name, 10);
  endtask

  task automatic manual(string name, int op, int ida, int idb, int kind, int rm_, int rn_, int code);
    start_sel(op, 1'b1);
    issue_ids(name, op, ida, idb, kind, rm_, rn_, code);
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_sel_a"}, int'(bus.sel_a), 0);
    chk({name, "_sel_b"}, int'(bus.sel_b), 0);
    chk({name, "_res_m"}, int'(bus.res_m), 0);
    chk({name, "_res_n"}, int'(bus.res_n), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_done"}, int'(bus.done), 0);
    chk({name, "_error"}, int'(bus.error), 0);
    chk({name, "_err_code"}, int'(bus.err_code), 0);
    chk({name, "_lfsr_seed"}, int'(dut.lfsr_q), 'hACE1);
  endtask

  initial begin
    int  n;
    bit  found;
    bit  rand_done;
    bus.start = 1'b0; bus.abort = 1'b0; bus.manual_mode = 1'b0; bus.op_type = '0;
    bus.user_id_a = '0; bus.user_id_b = '0; bus.user_valid = 1'b0;
    set_slot(0, 4, 5, 1); set_slot(1, 2, 3, 1); set_slot(2, 3, 3, 1); set_slot(3, 5, 5, 0);
    set_slot(4, 2, 2, 1); set_slot(5, 3, 3, 1); set_slot(6, 2, 5, 1); set_slot(7, 1, 1, 0);
    set_slot(8, 3, 4, 1); set_slot(9, 2, 3, 1);
    apply_meta();

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // manual selections: pass cases and each error reason
    manual("add_2_5",       1, 2, 5,  K_DONE, 3, 3, 0);
    manual("mul_mismatch",  3, 1, 4,  K_ERR,  0, 0, 4);
    manual("a_id_12",       1, 12, 5, K_ERR,  0, 0, 1);
    manual("transpose_6",   0, 6, 9,  K_DONE, 5, 2, 0);
    manual("mul_1_8",       3, 1, 8,  K_DONE, 2, 4, 0);
    manual("conv_0_9",      4, 0, 9,  K_DONE, 3, 3, 0);
    manual("scalar_b_empty",2, 8, 3,  K_DONE, 3, 4, 0);
    manual("a_empty",       1, 3, 2,  K_ERR,  0, 0, 2);
    manual("b_empty",       1, 2, 7,  K_ERR,  0, 0, 3);
    manual("b_id_10",       1, 2, 10, K_ERR,  0, 0, 3);
    manual("a_id_9_edge",   1, 9, 1,  K_DONE, 2, 3, 0);
    manual("a_id_10",       1, 10, 1, K_ERR,  0, 0, 1);
    manual("add_mismatch",  1, 2, 8,  K_ERR,  0, 0, 4);
    manual("conv_too_big",  4, 9, 0,  K_ERR,  0, 0, 4);

    // abort in ERR clears the error
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_err_error", int'(bus.error), 0);
    chk("abort_err_code", int'(bus.err_code), 0);
    chk("abort_err_busy", int'(bus.busy), 0);

    // start while busy is ignored
    start_sel(1, 1'b1);
    bus.op_type = 3'd6;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    chk("start_busy_still_busy", int'(bus.busy), 1);
    chk("start_busy_no_error", int'(bus.error), 0);
    issue_ids("start_busy_add", 1, 2, 5, K_DONE, 3, 3, 0);

    // abort beats user_valid; sel holds its old value
    start_sel(1, 1'b1);
    bus.user_id_a = 4'd6; bus.user_id_b = 4'd9;
    bus.user_valid = 1'b1; bus.abort = 1'b1;
    tick();
    bus.user_valid = 1'b0; bus.abort = 1'b0;
    chk("abort_wait_busy", int'(bus.busy), 0);
    chk("abort_wait_error", int'(bus.error), 0);
    chk("abort_wait_sel_a_held", int'(bus.sel_a), 2);
    repeat (4) tick();

    // illegal op, then re-arm from ERR
    push(K_ERR, "illegal_op", 6, 0, 0, 0, 0, 6, 0);
    start_sel(6, 1'b1);
    wait_sb("illegal_op", 5);
    start_sel(2, 1'b1);
    chk("rearm_error_cleared", int'(bus.error), 0);
    chk("rearm_code_cleared", int'(bus.err_code), 0);
    chk("rearm_busy", int'(bus.busy), 1);
    issue_ids("rearm_scalar", 2, 8, 0, K_DONE, 3, 4, 0);

    // synchronous reset while in CHECK
    start_sel(1, 1'b1);
    bus.user_id_a = 4'd2; bus.user_id_b = 4'd5; bus.user_valid = 1'b1;
    tick();
    bus.user_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_in_check");
    rst_n = 1'b1;
    repeat (4) tick();

    // random mode with an empty store: exactly MAX_TRIES draws then code 5
    for (int i = 0; i < SLOTS; i++) tv[i] = 1'b0;
    apply_meta();
    push(K_ERR, "exhaust", 1, 0, 0, 0, 0, 5, 0);
    start_sel(1, 1'b0);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
    chk("exhaust_busy_cycles", n, 17);
    chk("exhaust_busy_dropped", int'(bus.busy), 0);
    wait_sb("exhaust", 5);

    // random transpose over a full store
    for (int i = 0; i < SLOTS; i++) set_slot(i, (i % 7) + 1, ((i + 3) % 7) + 1, 1);
    apply_meta();
    rand_done = 1'b0;
    for (int a = 0; a < 10 && !rand_done; a++) begin
      rand_outcome = 0;
      push(K_RAND, "rand_transpose", 0, 0, 0, 0, 0, 0, 0);
      start_sel(0, 1'b0);
      wait_sb("rand_transpose", 60);
      if (rand_outcome == 1) rand_done = 1'b1;
    end
    chk("rand_transpose_completed", int'(rand_done), 1);

    // random conv with only slots 3 (4x4) and 7 (2x2) occupied
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1, 1, 0);
    set_slot(3, 4, 4, 1);
    set_slot(7, 2, 2, 1);
    apply_meta();
    rand_done = 1'b0;
    for (int a = 0; a < 40 && !rand_done; a++) begin
      rand_outcome = 0;
      push(K_RAND, "rand_conv", 4, 0, 0, 0, 0, 0, 0);
      start_sel(4, 1'b0);
      wait_sb("rand_conv", 80);
      if (rand_outcome == 1) rand_done = 1'b1;
    end
    chk("rand_conv_completed", int'(rand_done), 1);

    // abort while drawing B
    for (int i = 0; i < SLOTS; i++) set_slot(i, 3, 3, 1);
    apply_meta();
    start_sel(1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == 3'd3) found = 1'b1;
    end
    chk("abort_reached_rand_b", int'(found), 1);
    for (int i = 0; i < SLOTS; i++) tv[i] = 1'b0;
    apply_meta();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_rand_b_busy", int'(bus.busy), 0);
    chk("abort_rand_b_done", int'(bus.done), 0);
    chk("abort_rand_b_error", int'(bus.error), 0);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
